// File: rtl/mem_fifo_pkg.sv
// mem_fifo_pkg: shared constants and FSM state type for the mem_fifo_ctrl slice.
// The optional first-word fall-through path is enabled with MEM_FIFO_BYPASS_EN.
package mem_fifo_pkg;

   // RAM macro geometry and total FIFO capacity (RAM entries plus output register)
   localparam int MEM_DW    = 8;
   localparam int MEM_AW    = 2;
   localparam int MEM_DEPTH = 4;
   localparam int FIFO_CAP  = 5;

   // Read sequencer: IDLE, or waiting one cycle for the RAM read data
   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } fifo_state_t;

endpackage

// File: rtl/mem.sv
// mem: 4 x 8-bit single-port block RAM wrapper with a registered read port.
// A read issued in cycle N presents its data on dout during cycle N+1.
module mem
   import mem_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              oce,
   input  logic              wre,
   input  logic [MEM_AW-1:0] ad,
   input  logic [MEM_DW-1:0] din,
   output logic [MEM_DW-1:0] dout
);

   logic [MEM_DW-1:0] mem_array [MEM_DEPTH];

   // Storage array write port; contents are not cleared by reset
   always_ff @(posedge clk) begin
      if (ce && wre) begin
         mem_array[ad] <= din;
      end
   end

   // Registered read data, cleared by reset so no stale byte survives it
   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= '0;
      end else if (ce && oce && !wre) begin
         dout <= mem_array[ad];
      end
   end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: 5-byte FIFO (4 bytes in the single-port RAM plus a 1-byte
// output register) with valid/ready on both sides. Reads take priority over
// writes on the shared RAM port.
// Define MEM_FIFO_BYPASS_EN to let a byte arriving at an empty FIFO skip the RAM.
module mem_fifo_ctrl
   import mem_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [MEM_DW-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [MEM_DW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        count
);

   fifo_state_t       state;
   logic [MEM_AW-1:0] wr_ptr;
   logic [MEM_AW-1:0] rd_ptr;
   logic [2:0]        ram_count;

   logic              rd_pend;
   logic              out_free;
   logic              rd_issue;
   logic              bypass_load;
   logic              wr_en;
   logic              ram_ce;
   logic              ram_wre;
   logic [MEM_AW-1:0] ram_ad;
   logic [MEM_DW-1:0] ram_dout;

   // Arbitrate the single RAM port: refill the output register first, accept pushes otherwise
   always_comb begin
      rd_pend  = (state == RD_WAIT);
      out_free = !out_valid || out_ready;
      rd_issue = (ram_count != 3'd0) && !rd_pend && out_free;
      in_ready = !reset && (ram_count < 3'(MEM_DEPTH)) && !rd_issue;
`ifdef MEM_FIFO_BYPASS_EN
      bypass_load = (ram_count == 3'd0) && !rd_pend && out_free && in_valid && in_ready;
`else
      bypass_load = 1'b0;
`endif
      wr_en    = in_valid && in_ready && !bypass_load;
      ram_ce   = rd_issue || wr_en;
      ram_wre  = wr_en;
      ram_ad   = rd_issue ? rd_ptr : wr_ptr;
   end

   assign count = ram_count + {2'b00, rd_pend} + {2'b00, out_valid};

   // Pointers, RAM occupancy, read sequencer and the registered output byte
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (rd_issue) begin
            rd_ptr <= rd_ptr + 2'd1;
         end

         case ({wr_en, rd_issue})
            2'b10:   ram_count <= ram_count + 3'd1;
            2'b01:   ram_count <= ram_count - 3'd1;
            default: ram_count <= ram_count;
         endcase

         case (state)
            IDLE:    if (rd_issue) state <= RD_WAIT;
            RD_WAIT: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (rd_pend) begin
            out_data  <= ram_dout;
            out_valid <= 1'b1;
         end else if (bypass_load) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   mem u_mem (
      .clk   (clk),
      .reset (reset),
      .ce    (ram_ce),
      .oce   (1'b1),
      .wre   (ram_wre),
      .ad    (ram_ad),
      .din   (in_data),
      .dout  (ram_dout)
   );

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: directed, table-driven bench for mem_fifo_ctrl.
// Table expectations assume MEM_FIFO_BYPASS_EN undefined; with it defined a
// dedicated bypass sequence runs instead.
module tb_mem_fifo_ctrl;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       exp_ir;
      logic       exp_ov;
      logic [7:0] exp_od;
      logic [2:0] exp_cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] count;

   int applied = 0;
   int miscompares = 0;
   logic ce_seen = 1'b0;

   vec_t vecs[$];

   mem_fifo_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Record any RAM access, used by the bypass sequence
   always @(posedge clk) begin
      if (dut.ram_ce) ce_seen = 1'b1;
   end

   function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] id,
                               input logic ordy, input logic ir, input logic ov,
                               input logic [7:0] od, input logic [2:0] cnt);
      vec_t v;
      v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy;
      v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int idx,
                              input logic [7:0] act, input logic [7:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Called 1 unit after a rising edge; checks in_ready before the edge and state after it
   task automatic applyStimulus(input vec_t v, input int idx);
      reset     = v.rst;
      in_valid  = v.iv;
      in_data   = v.id;
      out_ready = v.ordy;
      #2;
      checkOutput("in_ready", idx, 8'(in_ready), 8'(v.exp_ir));
      @(posedge clk);
      #1;
      checkOutput("out_valid", idx, 8'(out_valid), 8'(v.exp_ov));
      checkOutput("out_data", idx, out_data, v.exp_od);
      checkOutput("count", idx, 8'(count), 8'(v.exp_cnt));
   endtask

   // Both sides always ready: 16 bytes must emerge in order
   task automatic streamTest();
      int sent = 0;
      int rcvd = 0;
      int cyc = 0;
      int first_acc = -1;
      int last_acc = -1;
      logic acc;
      logic popd;
      logic [7:0] got;
      reset = 1'b0;
      out_ready = 1'b1;
      while (rcvd < 16 && cyc < 200) begin
         in_valid = (sent < 16);
         in_data  = 8'(sent);
         #2;
         acc  = in_valid && in_ready;
         popd = out_valid && out_ready;
         got  = out_data;
         @(posedge clk);
         #1;
         if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            sent++;
         end
         if (popd) begin
            checkOutput("stream_data", rcvd, got, 8'(rcvd));
            rcvd++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checkOutput("stream_rcvd", 0, 8'(rcvd), 8'd16);
`ifndef MEM_FIFO_BYPASS_EN
      checkOutput("stream_span", 0, 8'(last_acc - first_acc), 8'd30);
`endif
   endtask

   initial begin
      @(posedge clk);
      #1;
`ifndef MEM_FIFO_BYPASS_EN
      // Single byte A5: out_valid three cycles after acceptance, then pop
      vecs.push_back(mk(1,0,8'h00,0, 0,0,8'h00,3'd0));
      vecs.push_back(mk(0,1,8'hA5,0, 1,0,8'h00,3'd1));
      vecs.push_back(mk(0,0,8'h00,0, 0,0,8'h00,3'd1));
      vecs.push_back(mk(0,0,8'h00,0, 1,1,8'hA5,3'd1));
      vecs.push_back(mk(0,0,8'h00,0, 1,1,8'hA5,3'd1));
      vecs.push_back(mk(0,0,8'h00,1, 1,0,8'hA5,3'd0));
      // Fill with 01..05 (02 held off by a read issue), overflow attempt, then drain in order
      vecs.push_back(mk(0,1,8'h01,0, 1,0,8'hA5,3'd1));
      vecs.push_back(mk(0,1,8'h02,0, 0,0,8'hA5,3'd1));
      vecs.push_back(mk(0,1,8'h02,0, 1,1,8'h01,3'd2));
      vecs.push_back(mk(0,1,8'h03,0, 1,1,8'h01,3'd3));
      vecs.push_back(mk(0,1,8'h04,0, 1,1,8'h01,3'd4));
      vecs.push_back(mk(0,1,8'h05,0, 1,1,8'h01,3'd5));
      vecs.push_back(mk(0,1,8'h06,0, 0,1,8'h01,3'd5));
      vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h01,3'd4));
      vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h02,3'd4));
      vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h02,3'd3));
      vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h03,3'd3));
      vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h03,3'd2));
      vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h04,3'd2));
      vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h04,3'd1));
      vecs.push_back(mk(0,0,8'h00,1, 1,1,8'h05,3'd1));
      vecs.push_back(mk(0,0,8'h00,1, 1,0,8'h05,3'd0));
      // Build count=3 in RD_WAIT, reset for one cycle, nothing stale afterwards
      vecs.push_back(mk(0,1,8'h11,0, 1,0,8'h05,3'd1));
      vecs.push_back(mk(0,1,8'h22,0, 0,0,8'h05,3'd1));
      vecs.push_back(mk(0,1,8'h22,0, 1,1,8'h11,3'd2));
      vecs.push_back(mk(0,1,8'h33,0, 1,1,8'h11,3'd3));
      vecs.push_back(mk(0,1,8'h44,0, 1,1,8'h11,3'd4));
      vecs.push_back(mk(0,0,8'h00,1, 0,0,8'h11,3'd3));
      vecs.push_back(mk(1,0,8'h00,0, 0,0,8'h00,3'd0));
      vecs.push_back(mk(0,0,8'h00,0, 1,0,8'h00,3'd0));
      vecs.push_back(mk(0,0,8'h00,1, 1,0,8'h00,3'd0));
      vecs.push_back(mk(0,0,8'h00,1, 1,0,8'h00,3'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end
`else
      // Bypass: 3C reaches the output register in one cycle without touching the RAM
      reset = 1'b0;
      @(posedge clk);
      #1;
      ce_seen   = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      out_ready = 1'b0;
      #2;
      checkOutput("byp_in_ready", 0, 8'(in_ready), 8'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("byp_out_valid", 0, 8'(out_valid), 8'd1);
      checkOutput("byp_out_data", 0, out_data, 8'h3C);
      checkOutput("byp_count", 0, 8'(count), 8'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("byp_ce", 0, 8'(ce_seen), 8'd0);
      checkOutput("byp_hold", 0, 8'(out_valid), 8'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("byp_reset_count", 0, 8'(count), 8'd0);
`endif
      streamTest();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
